// File: rtl/tick_scheduler_pkg.sv
// tick_sched_pkg: shared constants and types for the tick scheduler slice.
//   PRESCALE_DEF / NCH_DEF / PW_DEF : default build parameters
//   PW_MAX                          : widest supported period register
//   chw()                           : index width for an n-entry set (min 1)
//   ch_state_t                      : per-channel period P, down-counter C, pending R
package tick_sched_pkg;

  localparam int unsigned PRESCALE_DEF = 32'd1200000;
  localparam int unsigned NCH_DEF      = 32'd4;
  localparam int unsigned PW_DEF       = 32'd8;
  localparam int unsigned PW_MAX       = 32'd16;

  function automatic int unsigned chw(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : int'($clog2(n));
  endfunction

  // P and C are held at PW_MAX bits; only the low PW bits are ever non-zero.
  typedef struct packed {
    logic [PW_MAX-1:0] p;
    logic [PW_MAX-1:0] c;
    logic              r;
  } ch_state_t;

endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: period-write bus and event valid/ready stream.
//   period_we/period_sel/period_din : host writes a channel period
//   ev_valid/ev_ch                  : scheduler presents an event
//   ev_ready                        : consumer accepts the presented event
// modport master = host/consumer side, modport slave = scheduler side.
interface tick_scheduler_if
  import tick_sched_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned PW  = PW_DEF
);
  localparam int unsigned CHW = chw(NCH);

  logic           period_we;
  logic [CHW-1:0] period_sel;
  logic [PW-1:0]  period_din;
  logic           ev_valid;
  logic [CHW-1:0] ev_ch;
  logic           ev_ready;

  modport master (
    output period_we, period_sel, period_din, ev_ready,
    input  ev_valid, ev_ch
  );

  modport slave (
    input  period_we, period_sel, period_din, ev_ready,
    output ev_valid, ev_ch
  );

endinterface

// File: rtl/tick_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin selection over NCH request bits.
//   clki, rst : clock, synchronous active-high reset
//   req       : request bits
//   advance   : the current grant is being consumed this cycle
//   any       : at least one request present
//   gnt_oh    : one-hot grant
//   gnt_idx   : index of granted request
// The search is combinational; only the last-granted pointer is stored.
module rr_arbiter
  import tick_sched_pkg::*;
#(
  parameter  int unsigned NCH = NCH_DEF,
  localparam int unsigned CHW = chw(NCH)
) (
  input  logic           clki,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic           any,
  output logic [NCH-1:0] gnt_oh,
  output logic [CHW-1:0] gnt_idx
);

  logic [CHW-1:0] ptr_r;

  // First requester found scanning upward from one past the last grant.
  always_comb begin
    logic [CHW-1:0] idx_s;
    any     = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    idx_s   = '0;
    for (int unsigned k = 32'd1; k <= NCH; k++) begin
      idx_s = CHW'((int'(ptr_r) + k) % NCH);
      if (!any && req[idx_s]) begin
        any            = 1'b1;
        gnt_oh[idx_s]  = 1'b1;
        gnt_idx        = idx_s;
      end else begin
        any = any;
      end
    end
  end

  // Pointer tracks the last consumed grant; reset value makes channel 0 first.
  always_ff @(posedge clki) begin
    if (rst) begin
      ptr_r <= CHW'(NCH - 32'd1);
    end else if (advance && any) begin
      ptr_r <= gnt_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: one shared prescaler divided per channel into periodic
// events, serialised round-robin onto a valid/ready stream.
//   clki, rst, en : clock, synchronous active-high reset, prescaler run enable
//   bus (slave)   : period write port and event stream (tick_scheduler_if)
//   tick          : base tick, one clki cycle wide every PRESCALE cycles
//   overrun       : sticky per-channel missed-event flags, present only when
//                   TICK_SCHED_OVERRUN_EN is defined
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter  int unsigned PRESCALE = PRESCALE_DEF,
  parameter  int unsigned NCH      = NCH_DEF,
  parameter  int unsigned PW       = PW_DEF,
  localparam int unsigned CHW      = chw(NCH),
  localparam int unsigned CNTW     = chw(PRESCALE)
) (
  input  logic           clki,
  input  logic           rst,
  input  logic           en,
  tick_scheduler_if.slave bus,
  output logic           tick
`ifdef TICK_SCHED_OVERRUN_EN
  ,
  output logic [NCH-1:0] overrun
`endif
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PRESCALE - 32'd1);

  logic [CNTW-1:0] cnt_r;
  ch_state_t       ch_r [NCH];
  logic [NCH-1:0]  req_s;
  logic [NCH-1:0]  wr_s;
  logic [NCH-1:0]  expire_s;
  logic [NCH-1:0]  clr_s;
  logic [NCH-1:0]  gnt_oh_s;
  logic [CHW-1:0]  gnt_idx_s;
  logic            any_s;
  logic            load_s;
  logic            ev_valid_r;
  logic [CHW-1:0]  ev_ch_r;

  // Tick is decoded straight from the counter so it lands in cycle PRESCALE-1.
  assign tick = en && (cnt_r == CNT_LAST);

  // Free-running prescaler, frozen while en is low.
  always_ff @(posedge clki) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNTW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign load_s = !ev_valid_r || bus.ev_ready;

  // Per-channel write decode, expiry and grant-clear; a write masks that channel's tick.
  always_comb begin
    req_s    = '0;
    wr_s     = '0;
    expire_s = '0;
    clr_s    = '0;
    for (int i = 0; i < NCH; i++) begin
      req_s[i]    = ch_r[i].r;
      wr_s[i]     = bus.period_we && (bus.period_sel == CHW'(i));
      expire_s[i] = tick && !wr_s[i] && (ch_r[i].p != '0) && (ch_r[i].c == '0);
      clr_s[i]    = load_s && gnt_oh_s[i];
    end
  end

  // Channel array: write wins over tick, expiry set wins over grant-clear.
  always_ff @(posedge clki) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        ch_r[i] <= '0;
      end else if (wr_s[i]) begin
        ch_r[i].p <= PW_MAX'(bus.period_din);
        ch_r[i].c <= (bus.period_din == '0) ? '0 : PW_MAX'(bus.period_din - PW'(1));
        ch_r[i].r <= 1'b0;
      end else begin
        if (tick && (ch_r[i].p != '0)) begin
          if (ch_r[i].c == '0) begin
            ch_r[i].c <= ch_r[i].p - PW_MAX'(1);
          end else begin
            ch_r[i].c <= ch_r[i].c - PW_MAX'(1);
          end
        end else begin
          ch_r[i].c <= ch_r[i].c;
        end
        ch_r[i].p <= ch_r[i].p;
        if (expire_s[i]) begin
          ch_r[i].r <= 1'b1;
        end else if (clr_s[i]) begin
          ch_r[i].r <= 1'b0;
        end else begin
          ch_r[i].r <= ch_r[i].r;
        end
      end
    end
  end

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .clki    (clki),
    .rst     (rst),
    .req     (req_s),
    .advance (load_s),
    .any     (any_s),
    .gnt_oh  (gnt_oh_s),
    .gnt_idx (gnt_idx_s)
  );

  // Output register: reloads whenever empty or the consumer takes the event.
  always_ff @(posedge clki) begin
    if (rst) begin
      ev_valid_r <= 1'b0;
      ev_ch_r    <= '0;
    end else if (load_s) begin
      if (any_s) begin
        ev_valid_r <= 1'b1;
        ev_ch_r    <= gnt_idx_s;
      end else begin
        ev_valid_r <= 1'b0;
        ev_ch_r    <= ev_ch_r;
      end
    end else begin
      ev_valid_r <= ev_valid_r;
      ev_ch_r    <= ev_ch_r;
    end
  end

  assign bus.ev_valid = ev_valid_r;
  assign bus.ev_ch    = ev_ch_r;

`ifdef TICK_SCHED_OVERRUN_EN
  logic [NCH-1:0] overrun_r;

  // Sticky merge flag; an expiry coinciding with its own grant is not a merge.
  always_ff @(posedge clki) begin
    if (rst) begin
      overrun_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_s[i]) begin
          overrun_r[i] <= 1'b0;
        end else if (expire_s[i] && ch_r[i].r && !clr_s[i]) begin
          overrun_r[i] <= 1'b1;
        end else begin
          overrun_r[i] <= overrun_r[i];
        end
      end
    end
  end

  assign overrun = overrun_r;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed bench for tick_scheduler with PRESCALE=4, NCH=4.
// Cycle 0 is the first cycle after the last reset edge; inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_tick_scheduler;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned NCH      = 4;
  localparam int unsigned PW       = 8;

  logic clki = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  logic tick;
`ifdef TICK_SCHED_OVERRUN_EN
  logic [NCH-1:0] overrun;
`endif

  tick_scheduler_if #(.NCH(NCH), .PW(PW)) bus ();

  tick_scheduler #(
    .PRESCALE (PRESCALE),
    .NCH      (NCH),
    .PW       (PW)
  ) dut (
    .clki (clki),
    .rst  (rst),
    .en   (en),
    .bus  (bus),
    .tick (tick)
`ifdef TICK_SCHED_OVERRUN_EN
    ,
    .overrun (overrun)
`endif
  );

  always #5 clki = ~clki;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic step();
    @(posedge clki);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_ev(input string tag, input logic exp_valid, input logic [1:0] exp_ch);
    check({tag, "_valid"}, 32'(bus.ev_valid), 32'(exp_valid));
    if (exp_valid) check({tag, "_ch"}, 32'(bus.ev_ch), 32'(exp_ch));
  endtask

  task automatic do_reset(input logic en_v);
    rst = 1'b1;
    bus.period_we = 1'b0;
    bus.ev_ready  = 1'b1;
    en = en_v;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wr(input int ch, input int val);
    bus.period_we  = 1'b1;
    bus.period_sel = 2'(ch);
    bus.period_din = 8'(val);
  endtask

  initial begin
    bus.period_we  = 1'b0;
    bus.period_sel = 2'd0;
    bus.period_din = 8'd0;
    bus.ev_ready   = 1'b1;

    // Reset state and prescaler cadence
    do_reset(1'b1);
    check("rst_valid", 32'(bus.ev_valid), 32'd0);
    check("rst_ch", 32'(bus.ev_ch), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
`ifdef TICK_SCHED_OVERRUN_EN
    check("rst_overrun", 32'(overrun), 32'd0);
`endif
    for (int c = 0; c < 12; c++) begin
      check("tick_run", 32'(tick), 32'((cyc % 4) == 3));
      check("idle_valid", 32'(bus.ev_valid), 32'd0);
      step();
    end
    step();
    // cyc 13, counter 1: freeze for five cycles
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("tick_hold", 32'(tick), 32'd0);
      step();
    end
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("tick_resume", 32'(tick), 32'(cyc == 20));
      step();
    end

    // All four channels period 1, consecutive events 0,1,2,3 every round
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) begin
      wr(c, 1);
      step();
    end
    bus.period_we = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 21; c++) begin
      check_ev("rr", cyc >= 9, 2'((cyc - 1) % 4));
      step();
    end

    // ch0 period 3: event 2 cycles after every third tick
    do_reset(1'b1);
    wr(0, 3);
    step();
    bus.period_we = 1'b0;
    for (int c = 0; c < 27; c++) begin
      check_ev("per3", (cyc == 13) || (cyc == 25), 2'd0);
      step();
    end

    // ch1 period 2 written on a tick cycle: that tick is ignored for ch1
    do_reset(1'b1);
    step();
    step();
    step();
    check("wr_on_tick", 32'(tick), 32'd1);
    wr(1, 2);
    step();
    bus.period_we = 1'b0;
    for (int c = 0; c < 11; c++) begin
      check_ev("wrtick", cyc == 13, 2'd1);
      step();
    end

    // ch2 period 1 with consumer stalled across three ticks
    do_reset(1'b1);
    bus.ev_ready = 1'b0;
    wr(2, 1);
    step();
    bus.period_we = 1'b0;
    for (int c = 0; c < 13; c++) begin
      check_ev("stall", cyc >= 5, 2'd2);
`ifdef TICK_SCHED_OVERRUN_EN
      check("overrun", 32'(overrun), (cyc >= 12) ? 32'h4 : 32'h0);
`endif
      if (cyc == 13) bus.ev_ready = 1'b1;
      step();
    end
    for (int c = 0; c < 4; c++) begin
      check_ev("release", (cyc == 14) || (cyc == 17), 2'd2);
`ifdef TICK_SCHED_OVERRUN_EN
      check("overrun_sticky", 32'(overrun), 32'h4);
`endif
      step();
    end

    // Reset while an event is held and another is pending
    do_reset(1'b1);
    bus.ev_ready = 1'b0;
    wr(0, 1);
    step();
    wr(1, 1);
    step();
    bus.period_we = 1'b0;
    while (cyc < 6) step();
    check_ev("pre_rst", 1'b1, 2'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.ev_ready = 1'b1;
    cyc = 0;
    check("post_rst_ch", 32'(bus.ev_ch), 32'd0);
    for (int c = 0; c < 9; c++) begin
      check_ev("post_rst", 1'b0, 2'd0);
      check("post_rst_tick", 32'(tick), 32'((cyc % 4) == 3));
`ifdef TICK_SCHED_OVERRUN_EN
      check("post_rst_overrun", 32'(overrun), 32'd0);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel periodic event scheduler built around one shared prescaler. A single base tick is divided per channel by a programmable period. Expired channels raise pending requests, and a round-robin arbiter serialises them into one valid/ready event stream. The block sits between the clock domain's pulse generation and the multi-writer logic, so every periodic writer shares one counter instead of owning its own timer.

## Interface
- PRESCALE, 1200000: base tick period in clki cycles (≥2)
- NCH, 4: number of channels (2..16)
- PW, 8: channel period register width
- clki  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  prescaler run enable
- period_we  in  1  period write strobe
- period_sel  in  $clog2(NCH)  channel addressed by write
- period_din  in  PW  period in ticks; 0 disables the channel
- tick  out  1  base tick, one clki cycle wide
- ev_valid  out  1  event available
- ev_ch  out  $clog2(NCH)  channel of presented event
- ev_ready  in  1  consumer accepts event
- overrun  out  NCH  sticky missed-event flags (only with TICK_SCHED_OVERRUN_EN)

## Operation
- Prescaler counter runs 0..PRESCALE-1 and wraps to 0. tick = (count == PRESCALE-1) && en, decoded from registers. Period is exactly PRESCALE cycles.
- en=0: counter is held at current value, tick=0, and channel counters hold. Pending requests and the output continue to drain.
- Per channel: period reg P, down-counter C, pending bit R. On tick with P≠0: if C==0, set R and reload C=P-1; otherwise decrement C. P==0 means the channel is ignored and C is held.
- Period write: P=din, C=din-1 (0 if din==0), R cleared. A write coinciding with a tick on the same channel: the write wins and that tick is ignored for that channel.
- Output stage is a register. Load occurs when !ev_valid || ev_ready. If any R is set, the arbiter winner is loaded into ev_ch, ev_valid=1, and the winner's R is cleared. If no R is set, ev_valid=0.
- Round-robin: search starts at last granted channel +1 (mod NCH). After reset the search starts at channel 0.
- Grant-clear and a new expiry on the same channel in the same cycle: set wins, so the event is retained.
- Expiry while R is already set: the events merge (one delivered). This is an overrun.
- ev_valid && !ev_ready: ev_valid and ev_ch hold stable. The handshake completes only on a cycle where both are high.

## Timing
- Reset: counter=0, all P/C/R=0, ev_valid=0, ev_ch=0, tick=0, overrun=0, RR pointer=NCH-1.
- Tick in cycle T: R is visible in T+1. ev_valid rises in T+2 if the output stage is free.
- Sustained throughput: one event per cycle with ev_ready held high.
- First tick after rst release with en=1: cycle PRESCALE-1 (0-indexed).
- First event of a channel written with period N (write before the first tick): delivered on the N-th following tick.
- rst mid-operation: all state clears on the next edge. An in-flight event is dropped without handshake.

## Configuration
- TICK_SCHED_OVERRUN_EN defined: the overrun port exists.
  - overrun[i] sets on expiry while R[i]=1.
  - It is sticky and is cleared only by a period write to channel i or by rst.
- Not defined: the port and its logic are absent, and merged events are dropped silently.

## Structure
- Package tick_sched_pkg holds:
  - CHW=$clog2(NCH) helper
  - default PRESCALE/NCH/PW constants
  - channel state struct {P, C, R}
- Sub-module rr_arbiter (NCH request bits, pointer, one-hot/index grant, purely combinational search plus pointer register). The channel array and prescaler stay inline.

## Test plan
- PRESCALE=4, en=1 after reset -> tick high in cycles 3, 7, 11, …; all outputs 0 before cycle 3.
- ch0 period 3, ev_ready=1 -> ev_valid with ev_ch=0 every 12 cycles, first 2 cycles after the 3rd tick.
- ch0..3 all period 1, ev_ready=1 -> on each tick, events ev_ch 0,1,2,3 on four consecutive cycles. Next round also starts at 0, since the pointer wrapped from 3.
- ch2 period 1, ev_ready=0 for 3 ticks -> ev_valid=1 with ev_ch=2 held stable, a single event delivered on release, and overrun[2]=1 (macro on).
- Write ch1 period 2 in the same cycle as a tick -> no ch1 expiry from that tick; first ch1 event after the 2nd later tick.
- Assert rst while ev_valid=1 and R bits set -> next cycle ev_valid=0, all pending cleared, and the tick restarts at cycle PRESCALE-1.
